// File: rtl/pl_irq_pkg.sv
// Shared constants for the PL interrupt AXI4-Lite slave: register offsets,
// AXI response codes and the read/write FSM state types.
package pl_irq_pkg;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_FORCE   = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/pl_irq_edge_detect.sv
// Per-bit rising-edge detector for interrupt inputs. Macro PL_IRQ_INPUT_SYNC_EN
// inserts a 2-flop synchronizer in front of each detector.
module pl_irq_edge_detect #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_irq,
   output logic [WIDTH-1:0] o_rise
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic w_cond;
         logic r_prev;
`ifdef PL_IRQ_INPUT_SYNC_EN
         logic [1:0] r_sync;
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) r_sync <= 2'b00;
            else       r_sync <= {r_sync[0], i_irq[gi]};
         end
         assign w_cond = r_sync[1];
`else
         assign w_cond = i_irq[gi];
`endif
         // History clears on reset so a source held high re-arms afterwards.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) r_prev <= 1'b0;
            else       r_prev <= w_cond;
         end
         assign o_rise[gi] = w_cond & ~r_prev;
      end
   endgenerate

endmodule

// File: rtl/pl_irq_axil_slave.sv
// AXI4-Lite interrupt aggregator: ENABLE / sticky STATUS / FORCE / SCRATCH.
// Optional input synchronizer selected by macro PL_IRQ_INPUT_SYNC_EN.
module pl_irq_axil_slave
   import pl_irq_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_IRQ            = 8
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic [NUM_IRQ-1:0]              irq_in,
   output logic                            irq_out
);

   wr_state_t          r_wr_state;
   rd_state_t          r_rd_state;
   logic               r_awready, r_wready, r_bvalid, r_aw_done, r_w_done;
   logic               r_arready, r_rvalid, r_irq;
   logic [1:0]         r_awsel;
   logic [3:0]         r_wstrb;
   logic [31:0]        r_wdata, r_rdata, r_scratch;
   logic [NUM_IRQ-1:0] r_enable, r_status;

   logic               w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_wr_en, w_ar_hs;
   logic [1:0]         w_wsel;
   logic [3:0]         w_wstrb;
   logic [31:0]        w_wdata, w_bmask, w_wbits, w_rd_mux;
   logic [NUM_IRQ-1:0] w_rise, w_status_clr, w_status_set;
   logic               w_unused_ok;

   assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // A channel arriving on the completing edge is used directly, so the
   // register update lands on the same edge that enters WR_RESP.
   assign w_aw_hs   = r_awready & S_AXI_AWVALID;
   assign w_w_hs    = r_wready & S_AXI_WVALID;
   assign w_aw_have = r_aw_done | w_aw_hs;
   assign w_w_have  = r_w_done | w_w_hs;
   assign w_wr_en   = (r_wr_state == WR_IDLE) & w_aw_have & w_w_have;
   assign w_wsel    = w_aw_hs ? S_AXI_AWADDR[3:2] : r_awsel;
   assign w_wdata   = w_w_hs ? S_AXI_WDATA : r_wdata;
   assign w_wstrb   = w_w_hs ? S_AXI_WSTRB : r_wstrb;
   assign w_wbits   = w_wdata & w_bmask;
   assign w_ar_hs   = r_arready & S_AXI_ARVALID;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bmask
         assign w_bmask[gi*8 +: 8] = {8{w_wstrb[gi]}};
      end
   endgenerate

   pl_irq_edge_detect #(.WIDTH(NUM_IRQ)) u_edge (
      .i_clk  (ACLK),
      .i_rst  (ARESET),
      .i_irq  (irq_in),
      .o_rise (w_rise)
   );

   assign w_status_clr = (w_wr_en && w_wsel == REG_STATUS) ? w_wbits[NUM_IRQ-1:0] : '0;
   assign w_status_set = w_rise | ((w_wr_en && w_wsel == REG_FORCE) ? w_wbits[NUM_IRQ-1:0] : '0);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wr_state <= WR_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_awsel    <= 2'b00;
         r_wdata    <= '0;
         r_wstrb    <= '0;
      end else begin
         case (r_wr_state)
            WR_IDLE: begin
               if (w_aw_hs) r_awsel <= S_AXI_AWADDR[3:2];
               if (w_w_hs) begin
                  r_wdata <= S_AXI_WDATA;
                  r_wstrb <= S_AXI_WSTRB;
               end
               if (w_wr_en) begin
                  r_wr_state <= WR_RESP;
                  r_bvalid   <= 1'b1;
                  r_awready  <= 1'b0;
                  r_wready   <= 1'b0;
                  r_aw_done  <= 1'b0;
                  r_w_done   <= 1'b0;
               end else begin
                  r_aw_done  <= w_aw_have;
                  r_w_done   <= w_w_have;
                  r_awready  <= ~w_aw_have;
                  r_wready   <= ~w_w_have;
               end
            end
            WR_RESP: begin
               if (S_AXI_BREADY) begin
                  r_wr_state <= WR_IDLE;
                  r_bvalid   <= 1'b0;
                  r_awready  <= 1'b1;
                  r_wready   <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_enable  <= '0;
         r_status  <= '0;
         r_scratch <= '0;
         r_irq     <= 1'b0;
      end else begin
         // Set has priority over a same-cycle write-one-to-clear.
         r_status <= (r_status & ~w_status_clr) | w_status_set;
         if (w_wr_en && w_wsel == REG_ENABLE)
            r_enable <= (r_enable & ~w_bmask[NUM_IRQ-1:0]) | w_wbits[NUM_IRQ-1:0];
         if (w_wr_en && w_wsel == REG_SCRATCH)
            r_scratch <= (r_scratch & ~w_bmask) | w_wbits;
         r_irq <= |(r_status & r_enable);
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         REG_ENABLE:  w_rd_mux = 32'(r_enable);
         REG_STATUS:  w_rd_mux = 32'(r_status);
         REG_SCRATCH: w_rd_mux = r_scratch;
         default:     w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rd_state <= RD_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         case (r_rd_state)
            RD_IDLE: begin
               if (w_ar_hs) begin
                  r_rd_state <= RD_DATA;
                  r_rdata    <= w_rd_mux;
                  r_rvalid   <= 1'b1;
                  r_arready  <= 1'b0;
               end else begin
                  r_arready  <= 1'b1;
               end
            end
            RD_DATA: begin
               if (S_AXI_RREADY) begin
                  r_rd_state <= RD_IDLE;
                  r_rvalid   <= 1'b0;
                  r_arready  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign irq_out       = r_irq;

endmodule

// File: tb/tb_pl_irq_axil_slave.sv
// Directed bench for pl_irq_axil_slave: register map, interrupt path,
// channel ordering, strobes, concurrent read/write and reset behaviour.
module tb_pl_irq_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [3:0]  S_AXI_AWADDR = '0;
   logic [2:0]  S_AXI_AWPROT = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [3:0]  S_AXI_ARADDR = '0;
   logic [2:0]  S_AXI_ARPROT = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic [7:0]  irq_in = '0;
   logic        irq_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ACLK = ~ACLK;

   pl_irq_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_IRQ(8)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .irq_in(irq_in), .irq_out(irq_out)
   );

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int   n;
      logic aw_hs, w_hs;
      @(negedge ACLK);
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      n = 0;
      while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(negedge ACLK);
         if (aw_hs) S_AXI_AWVALID = 1'b0;
         if (w_hs)  S_AXI_WVALID  = 1'b0;
         n++;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_resp addr=%h: bvalid=%b bresp=%b, expected 1/00", addr, S_AXI_BVALID, S_AXI_BRESP);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      $display("write addr=%h data=%h strb=%b", addr, data, strb);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
      int   n;
      logic hs;
      @(negedge ACLK);
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (S_AXI_ARVALID && n < 20) begin
         hs = S_AXI_ARVALID && S_AXI_ARREADY;
         @(negedge ACLK);
         if (hs) S_AXI_ARVALID = 1'b0;
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      n_checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RRESP !== 2'b00) begin
         n_fail++;
         $display("FAIL rd_resp addr=%h: rvalid=%b rresp=%b, expected 1/00", addr, S_AXI_RVALID, S_AXI_RRESP);
      end
      data = S_AXI_RDATA;
      S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0;
      $display("read  addr=%h data=%h", addr, data);
   endtask

   task automatic check_read(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      n_checks++;
      if (d !== exp) begin
         n_fail++;
         $display("FAIL %s: read %h, expected %h", name, d, exp);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge ACLK);
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq_out} !== 6'b0
          || S_AXI_RDATA !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: aw/w/ar/b/r/irq=%b%b%b%b%b%b rdata=%h, expected all 0",
                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq_out, S_AXI_RDATA);
      end
      ARESET = 1'b0;
      #1;
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
         n_fail++;
         $display("FAIL ready_after_deassert: %b, expected 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      @(negedge ACLK);
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         n_fail++;
         $display("FAIL ready_first_edge: %b, expected 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      check_read("reset_enable", 4'h0, 32'h0);
      check_read("reset_status", 4'h4, 32'h0);
      check_read("reset_scratch", 4'hC, 32'h0);
   endtask

   task automatic test_regmap();
      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h2, 4'hF);
      axi_write(4'h8, 32'h4, 4'hF);
      axi_write(4'hC, 32'h4, 4'hF);
      check_read("map_enable", 4'h0, 32'h1);
      check_read("map_status", 4'h4, 32'h4);
      check_read("map_force", 4'h8, 32'h0);
      check_read("map_scratch", 4'hC, 32'h4);
      n_checks++;
      if (irq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL map_irq_out: %b, expected 0", irq_out);
      end
   endtask

   task automatic test_irq_pulse();
      axi_write(4'h0, 32'hFF, 4'hF);
      axi_write(4'h4, 32'hFF, 4'hF);
      n_checks++;
      if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_idle: %b, expected 0", irq_out); end
      @(negedge ACLK); irq_in[3] = 1'b1;
      @(negedge ACLK); irq_in[3] = 1'b0;
      n_checks++;
      if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_lag: %b, expected 0", irq_out); end
      @(negedge ACLK);
      n_checks++;
      if (irq_out !== 1'b1) begin n_fail++; $display("FAIL irq_rise: %b, expected 1", irq_out); end
      check_read("pulse_status", 4'h4, 32'h08);
      @(negedge ACLK);
      S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h08; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_checks++;
      if (irq_out !== 1'b1 || S_AXI_BVALID !== 1'b1) begin
         n_fail++; $display("FAIL irq_clear_lag: irq=%b bvalid=%b, expected 1/1", irq_out, S_AXI_BVALID);
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      n_checks++;
      if (irq_out !== 1'b0) begin n_fail++; $display("FAIL irq_fall: %b, expected 0", irq_out); end
      check_read("cleared_status", 4'h4, 32'h0);
   endtask

   task automatic test_w_before_aw();
      int cnt;
      @(negedge ACLK);
      S_AXI_WDATA = 32'hCAFE0001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_WVALID = 1'b0;
      n_checks++;
      if (S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL w_only: wready=%b bvalid=%b awready=%b, expected 0/0/1", S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY);
      end
      repeat (2) @(negedge ACLK);
      check_read("no_update_before_aw", 4'hC, 32'h4);
      S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (S_AXI_BVALID) cnt++;
         @(negedge ACLK);
      end
      n_checks++;
      if (cnt != 5) begin n_fail++; $display("FAIL bvalid_hold: %0d cycles, expected 5", cnt); end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (S_AXI_BVALID) cnt++;
         @(negedge ACLK);
      end
      n_checks++;
      if (cnt != 0) begin n_fail++; $display("FAIL single_response: %0d extra bvalid cycles, expected 0", cnt); end
      check_read("w_first_scratch", 4'hC, 32'hCAFE0001);
   endtask

   task automatic test_w1c_vs_set();
      @(negedge ACLK);
      S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; irq_in[0] = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      check_read("set_wins", 4'h4, 32'h1);
      irq_in[0] = 1'b0;
      axi_write(4'h4, 32'h1, 4'hF);
      check_read("w1c_plain", 4'h4, 32'h0);
   endtask

   task automatic test_strobe();
      axi_write(4'hC, 32'h0, 4'hF);
      axi_write(4'hC, 32'hDEADBEEF, 4'b0101);
      check_read("scratch_strobe", 4'hC, 32'h00AD00EF);
      axi_write(4'h0, 32'h0000FF00, 4'b0010);
      check_read("enable_strobe", 4'h0, 32'hFF);
      axi_write(4'h0, 32'hFFFFFF00, 4'hF);
      check_read("enable_width", 4'h0, 32'h0);
   endtask

   task automatic test_rw_same_cycle();
      @(negedge ACLK);
      S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1;
      S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h00AD00EF || S_AXI_BVALID !== 1'b1) begin
         n_fail++;
         $display("FAIL rw_same: rvalid=%b rdata=%h bvalid=%b, expected 1/00ad00ef/1", S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID);
      end
      @(negedge ACLK);
      n_checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h00AD00EF) begin
         n_fail++; $display("FAIL rdata_hold: rvalid=%b rdata=%h, expected 1/00ad00ef", S_AXI_RVALID, S_AXI_RDATA);
      end
      S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      $display("read/write same cycle addr=c");
      check_read("rw_post_write", 4'hC, 32'h11223344);
   endtask

   task automatic test_irq_across_reset();
      @(negedge ACLK);
      irq_in[5] = 1'b1; ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      check_read("held_irq_status", 4'h4, 32'h20);
      check_read("held_irq_enable", 4'h0, 32'h0);
      irq_in[5] = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      @(negedge ACLK);
      S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h55AA55AA; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      n_checks++;
      if (S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL mid_bvalid: %b, expected 1", S_AXI_BVALID); end
      #1 ARESET = 1'b1;
      #1;
      n_checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: bvalid=%b awready=%b, expected 0/0", S_AXI_BVALID, S_AXI_AWREADY);
      end
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      n_checks++;
      if (S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL stale_bvalid: %b, expected 0", S_AXI_BVALID); end
      check_read("rst_enable", 4'h0, 32'h0);
      check_read("rst_status", 4'h4, 32'h0);
      check_read("rst_force", 4'h8, 32'h0);
      check_read("rst_scratch", 4'hC, 32'h0);
   endtask

   initial begin
      test_reset();
      test_regmap();
      test_irq_pulse();
      test_w_before_aw();
      test_w1c_vs_set();
      test_strobe();
      test_rw_same_cycle();
      test_irq_across_reset();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
